dct_zigzag_serializer: RTL and testbench
========================================

DCT_ZIGZAG_SERIALIZER -- requirements
Module: dct_zigzag_serializer

Interface
REQ-001 SHALL have parameter IN_W, default 32, width of each signed fixed-point DCT coefficient word.
REQ-002 SHALL have parameter FRAC, default 8, number of fractional bits in each input word.
REQ-003 SHALL have parameter OUT_W, default 16, width of each signed integer output coefficient.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, upstream block valid.
REQ-007 SHALL have port in_block, input, IN_W*64, 8x8 block in raster order; word i = row i/8, col i%8, bits [i*IN_W +: IN_W].
REQ-008 SHALL have port in_ready, output, 1, block accepted on an edge where in_valid && in_ready.
REQ-009 SHALL have port out_valid, output, 1, coefficient valid.
REQ-010 SHALL have port out_data, output, OUT_W, signed integer coefficient.
REQ-011 SHALL have port out_index, output, 6, zigzag position 0..63 of out_data.
REQ-012 SHALL have port out_last, output, 1, high when out_valid and out_index==63.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts a beat on an edge where out_valid && out_ready.

Function
REQ-014 SHALL implement two states: IDLE (no block held) and SEND (block buffered, streaming).
REQ-015 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-016 On an accepted block, the block SHALL be stored, the counter cleared to 0, and state set to SEND; out_valid SHALL be 1 from the next cycle (1-cycle latency).
REQ-017 In SEND, out_valid SHALL be 1 and out_data SHALL equal the converted buffer word at raster position ZZ[cnt], where ZZ is the standard JPEG zigzag table (0,1,8,16,9,2,3,10,17,24,...,55,62,63).
REQ-018 out_index SHALL equal cnt; the counter SHALL advance by 1 on each accepted beat only.
REQ-019 While out_valid && !out_ready, out_data, out_index and out_last SHALL hold unchanged.
REQ-020 In SEND, in_ready SHALL be 1 only when cnt==63 && out_ready (combinational from out_ready); otherwise 0.
REQ-021 On an accepted beat with cnt==63: if a new block is accepted on the same edge, it SHALL be loaded, cnt set to 0, and SEND retained (no bubble, 64 beats per block); otherwise state SHALL return to IDLE.
REQ-022 Conversion SHALL compute the value in IN_W+1 bits (no intermediate overflow), arithmetically shift right by FRAC, then saturate to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-023 A block SHALL never be overwritten before beat 63 is accepted.

Reset
REQ-024 Assertion of rst_n low SHALL immediately force state IDLE, cnt=0, buffer=0, out_valid=0, out_last=0, out_index=0, out_data=0, in_ready=1, independent of clk.
REQ-025 Reset mid-block SHALL discard the remaining beats; the first edge after release SHALL accept a new block if in_valid=1.

Configuration
REQ-026 Macro ZZ_ROUND_EN defined: SHALL add 2^(FRAC-1) before the shift (round half toward +inf).
REQ-027 Macro ZZ_ROUND_EN undefined: SHALL apply plain arithmetic shift (floor); all other behaviour identical.

Verification
REQ-028 Word i = i<<8, out_ready=1 -> out_data sequence 0,1,8,16,9,2,3,10,... with out_index 0..63 and out_last only at beat 63.
REQ-029 Word 0x00000180 (1.5) -> 2 with ZZ_ROUND_EN, 1 without; 0xFFFFFE80 (-1.5) -> -1 with, -2 without.
REQ-030 Word 0x7FFFFF00 -> 0x7FFF; word 0x80000000 -> 0x8000 (OUT_W=16), in both configurations.
REQ-031 Second block held valid during beat 63 with out_ready=1 -> in_ready=1 that cycle, block-2 beat 0 on next cycle, 128 beats in 128 cycles.
REQ-032 out_ready=0 for 3 cycles at out_index=10 -> outputs held, resume at index 10, no skipped or duplicated beats, in_ready stays 0.
REQ-033 rst_n pulsed low at out_index=20 -> out_valid=0 and in_ready=1 immediately; next block streams from index 0.

Source files
------------

// File: rtl/dct_zigzag_serializer.sv
// Buffers one 8x8 fixed-point DCT block and streams it out in JPEG zigzag order as saturated integers.
// Define ZZ_ROUND_EN to round half toward +inf before the shift; the default build truncates (floor).
module dct_zigzag_serializer #(
  parameter int IN_W  = 32,
  parameter int FRAC  = 8,
  parameter int OUT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [IN_W*64-1:0]     in_block,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [OUT_W-1:0]       out_data,
  output logic [5:0]             out_index,
  output logic                   out_last,
  input  logic                   out_ready
);

  typedef enum logic {IDLE, SEND} state_e;

  // Raster position of each zigzag slot.
  localparam logic [5:0] ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  localparam logic signed [IN_W:0] SAT_MAX = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] SAT_MIN = {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};
`ifdef ZZ_ROUND_EN
  localparam logic signed [IN_W:0] HALF = (IN_W+1)'(1) << (FRAC-1);
`endif

  state_e                 state_q, state_d;
  logic [5:0]             cnt_q, cnt_d;
  logic [63:0][IN_W-1:0]  blk_q, blk_d;

  logic [IN_W-1:0]        sel;
  logic signed [IN_W:0]   word_x, word_r, word_s;

  // Conversion: one extra bit of headroom so the rounding add cannot wrap.
  always_comb begin
    sel    = blk_q[ZZ[cnt_q]];
    word_x = {sel[IN_W-1], sel};
`ifdef ZZ_ROUND_EN
    word_r = word_x + HALF;
`else
    word_r = word_x;
`endif
    word_s = word_r >>> FRAC;
    if (word_s > SAT_MAX)      out_data = SAT_MAX[OUT_W-1:0];
    else if (word_s < SAT_MIN) out_data = SAT_MIN[OUT_W-1:0];
    else                       out_data = word_s[OUT_W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    blk_d     = blk_q;
    out_valid = (state_q == SEND);
    out_index = cnt_q;
    out_last  = out_valid && (cnt_q == 6'd63);
    // A new block may only land as the last beat of the current one leaves.
    in_ready  = (state_q == IDLE) || (cnt_q == 6'd63 && out_ready);
    if (in_valid && in_ready) begin
      blk_d   = in_block;
      cnt_d   = 6'd0;
      state_d = SEND;
    end else if (state_q == SEND && out_ready) begin
      if (cnt_q == 6'd63) state_d = IDLE;
      else                cnt_d   = cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
    end
  end

endmodule

// File: tb/tb_dct_zigzag_serializer.sv
// Directed bench for dct_zigzag_serializer: ordering, conversion corners, back-to-back, stall, reset.
module tb_dct_zigzag_serializer;
  localparam int IN_W = 32, FRAC = 8, OUT_W = 16;

  logic                 clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [IN_W*64-1:0]   in_block = '0;
  logic                 in_ready, out_valid, out_last;
  logic [OUT_W-1:0]     out_data;
  logic [5:0]           out_index;

  dct_zigzag_serializer #(.IN_W(IN_W), .FRAC(FRAC), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_block(in_block), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int zz [64];
  int exp_a [64], exp_b [64], eb_r [64];
  logic [IN_W*64-1:0] blk_a, blk_b;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic beat(input int e, input int d);
    chk($sformatf("vld@%0d", e), 32'(out_valid), 1);
    chk($sformatf("idx@%0d", e), 32'(out_index), e);
    chk($sformatf("dat@%0d", e), 32'($signed(out_data)), d);
    chk($sformatf("last@%0d", e), 32'(out_last), (e == 63) ? 1 : 0);
  endtask

  // Called at a negedge; presents a block for one edge.
  task automatic load(input logic [IN_W*64-1:0] blk);
    in_block = blk;
    in_valid = 1'b1;
    chk("ld_rdy", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int n, e, stall;
    // Zigzag walk over anti-diagonals, independent of the RTL table.
    n = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) zz[n++] = r * 8 + (s - r);
      else            for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) zz[n++] = r * 8 + (s - r);
    end
    for (int i = 0; i < 64; i++) begin
      blk_a[i*IN_W +: IN_W] = 32'(i) << 8;
      blk_b[i*IN_W +: IN_W] = 32'(-(i * 256));
      eb_r[i] = -i;
    end
    blk_b[0*IN_W +: IN_W]  = 32'h0000_0180;
    blk_b[1*IN_W +: IN_W]  = 32'hFFFF_FE80;
    blk_b[8*IN_W +: IN_W]  = 32'h7FFF_FF00;
    blk_b[16*IN_W +: IN_W] = 32'h8000_0000;
`ifdef ZZ_ROUND_EN
    eb_r[0] = 2;  eb_r[1] = -1;
`else
    eb_r[0] = 1;  eb_r[1] = -2;
`endif
    eb_r[8] = 32767; eb_r[16] = -32768;
    for (int k = 0; k < 64; k++) begin
      exp_a[k] = zz[k];
      exp_b[k] = eb_r[zz[k]];
    end

    // Reset state
    #3;
    chk("rst_vld",  32'(out_valid), 0);
    chk("rst_rdy",  32'(in_ready), 1);
    chk("rst_dat",  32'(out_data), 0);
    chk("rst_idx",  32'(out_index), 0);
    chk("rst_last", 32'(out_last), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Ordering, single block
    load(blk_a);
    for (int k = 0; k < 64; k++) begin
      beat(k, exp_a[k]);
      if (k == 5) chk("send_rdy", 32'(in_ready), 0);
      @(negedge clk);
    end
    chk("idle_vld", 32'(out_valid), 0);
    chk("idle_rdy", 32'(in_ready), 1);

    // Back-to-back: block B waits for beat 63 of block A
    load(blk_a);
    in_block = blk_b;
    in_valid = 1'b1;
    for (int k = 0; k < 128; k++) begin
      e = k % 64;
      beat(e, (k < 64) ? exp_a[e] : exp_b[e]);
      chk($sformatf("b2b_rdy@%0d", k), 32'(in_ready), (e == 63) ? 1 : 0);
      if (k >= 64) in_valid = 1'b0;
      @(negedge clk);
    end
    chk("b2b_end", 32'(out_valid), 0);

    // Backpressure: 3 stalled cycles at index 10
    load(blk_a);
    e = 0; stall = 0;
    for (int c = 0; c < 67 && e < 64; c++) begin
      beat(e, exp_a[e]);
      if (e == 10 && stall < 3) begin
        out_ready = 1'b0;
        chk("stall_rdy", 32'(in_ready), 0);
        stall++;
      end else begin
        out_ready = 1'b1;
        e++;
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("stall_cnt", e, 64);
    chk("stall_end", 32'(out_valid), 0);

    // Reset mid-block at index 20, then a fresh block streams from 0
    load(blk_a);
    for (int k = 0; k < 20; k++) @(negedge clk);
    beat(20, exp_a[20]);
    rst_n = 1'b0;
    #1;
    chk("mrst_vld", 32'(out_valid), 0);
    chk("mrst_rdy", 32'(in_ready), 1);
    chk("mrst_idx", 32'(out_index), 0);
    in_block = blk_b;
    in_valid = 1'b1;
    #1 rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 64; k++) begin
      beat(k, exp_b[k]);
      @(negedge clk);
    end
    chk("mrst_end", 32'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
